// File: rtl/somador_serial.sv
// somador_serial: handshaked multi-cycle adder, FATIA bits per clock, LSB slice first.
// One FATIA-bit adder plus a registered carry walks the operands over N = LARGURA/FATIA cycles.
// Optional feature macro: SOMADOR_SUB_EN adds the sub port (a - b - cin, cout = borrow).
module somador_serial #(
  parameter int LARGURA = 32,
  parameter int FATIA   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  input  logic               cin,
`ifdef SOMADOR_SUB_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LARGURA-1:0] s,
  output logic               cout,
  output logic               ovf,
  output logic               zero
);

  localparam int N  = LARGURA / FATIA;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {OCIOSO, SOMANDO, PRONTO} estado_t;

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
  logic                 carry_q, carry_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
`ifdef SOMADOR_SUB_EN
  logic                 sub_q, sub_d;
`endif

  logic [FATIA-1:0]     fa, fb, fs;
  logic                 fc, msb_cin;

  // Single slice adder: slice cnt_q of the latched operands plus the running carry.
  always_comb begin
    fa      = a_q[int'(cnt_q)*FATIA +: FATIA];
    fb      = b_q[int'(cnt_q)*FATIA +: FATIA];
    {fc, fs} = {1'b0, fa} + {1'b0, fb} + {{FATIA{1'b0}}, carry_q};
    // Carry into the top bit of the slice, recovered from its sum bit.
    msb_cin = fa[FATIA-1] ^ fb[FATIA-1] ^ fs[FATIA-1];
  end

  // Next-state logic: accept, walk the slices, hold the result until consumed.
  always_comb begin
    estado_d = estado_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`ifdef SOMADOR_SUB_EN
    sub_d    = sub_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef SOMADOR_SUB_EN
          // Subtraction as a + ~b + ~cin; sub is remembered to flip the final carry into a borrow.
          sub_d   = sub;
          if (sub) begin
            b_d     = ~b;
            carry_d = ~cin;
          end
`endif
          estado_d = SOMANDO;
        end
      end
      SOMANDO: begin
        s_d[int'(cnt_q)*FATIA +: FATIA] = fs;
        carry_d = fc;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
`ifdef SOMADOR_SUB_EN
          cout_d = fc ^ sub_q;
`else
          cout_d = fc;
`endif
          ovf_d    = msb_cin ^ fc;
          zero_d   = (s_d == '0);
          cnt_d    = '0;
          estado_d = PRONTO;
        end
      end
      PRONTO: begin
        if (out_ready) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= OCIOSO;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SOMADOR_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
`ifdef SOMADOR_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign in_ready  = (estado_q == OCIOSO);
  assign out_valid = (estado_q == PRONTO);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
